// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 Set-2 scan code to one-cycle ASCII key event decoder
// Optional caps lock support is compiled in by defining PS2_CAPS_LOCK_EN.
module ps2_scancode_decoder #(
  parameter logic SUPPRESS_REPEAT = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_ready,
  output logic [7:0] ascii_char,
  output logic       key_pressed,
  output logic       shift_held,
  output logic       caps_on
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t     state_q, state_d;
  logic [7:0] ascii_q, ascii_d;
  logic       key_q, key_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  logic [7:0] last_make_q, last_make_d;

  logic       ignored, do_make, do_ext, do_brk, upper, repeat_blocked;
  logic [7:0] mapped;

  // Letters come back lowercase; anything at or above 'a' is a letter.
  function automatic logic [7:0] map_make(input logic [7:0] code, input logic up);
    logic [7:0] c;
    c = 8'h00;
    case (code)
      8'h1C: c = 8'h61; 8'h32: c = 8'h62; 8'h21: c = 8'h63; 8'h23: c = 8'h64;
      8'h24: c = 8'h65; 8'h2B: c = 8'h66; 8'h34: c = 8'h67; 8'h33: c = 8'h68;
      8'h43: c = 8'h69; 8'h3B: c = 8'h6A; 8'h42: c = 8'h6B; 8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D; 8'h31: c = 8'h6E; 8'h44: c = 8'h6F; 8'h4D: c = 8'h70;
      8'h15: c = 8'h71; 8'h2D: c = 8'h72; 8'h1B: c = 8'h73; 8'h2C: c = 8'h74;
      8'h3C: c = 8'h75; 8'h2A: c = 8'h76; 8'h1D: c = 8'h77; 8'h22: c = 8'h78;
      8'h35: c = 8'h79; 8'h1A: c = 8'h7A;
      8'h45: c = 8'h30; 8'h16: c = 8'h31; 8'h1E: c = 8'h32; 8'h26: c = 8'h33;
      8'h25: c = 8'h34; 8'h2E: c = 8'h35; 8'h36: c = 8'h36; 8'h3D: c = 8'h37;
      8'h3E: c = 8'h38; 8'h46: c = 8'h39;
      8'h29: c = 8'h20; 8'h49: c = 8'h2E; 8'h4E: c = 8'h2D; 8'h41: c = 8'h2C;
      8'h5A: c = 8'h0A; 8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if (up && c >= 8'h61) c = c - 8'h20;
    return c;
  endfunction

  always_comb begin
    ignored = (scan_code == 8'h00) || (scan_code == 8'hAA) || (scan_code == 8'hEE) ||
              (scan_code == 8'hFA) || (scan_code == 8'hFE) || (scan_code == 8'hFF);
    state_d = state_q;
    do_make = 1'b0;
    do_ext  = 1'b0;
    do_brk  = 1'b0;
    if (scan_ready) begin
      if (ignored) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (scan_code == 8'hE0)      state_d = EXT;
            else if (scan_code == 8'hF0) state_d = BRK;
            else                         do_make = 1'b1;
          end
          EXT: begin
            if (scan_code == 8'hF0)      state_d = EXT_BRK;
            else if (scan_code != 8'hE0) begin do_ext = 1'b1; state_d = IDLE; end
          end
          BRK: begin
            if (scan_code == 8'hE0)      state_d = EXT_BRK;
            else if (scan_code != 8'hF0) begin do_brk = 1'b1; state_d = IDLE; end
          end
          default: begin
            if (scan_code != 8'hF0 && scan_code != 8'hE0) begin
              do_brk  = 1'b1;
              state_d = IDLE;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    ascii_d        = ascii_q;
    key_d          = 1'b0;
    lshift_d       = lshift_q;
    rshift_d       = rshift_q;
    caps_d         = caps_q;
    caps_held_d    = caps_held_q;
    last_make_d    = last_make_q;
    upper          = (lshift_q | rshift_q) ^ caps_q;
    mapped         = do_ext ? ((scan_code == 8'h5A) ? 8'h0A : 8'h00) : map_make(scan_code, upper);
    repeat_blocked = (SUPPRESS_REPEAT != 1'b0) && (scan_code == last_make_q);
    if (do_make) begin
      if (scan_code == 8'h12) lshift_d = 1'b1;
      if (scan_code == 8'h59) rshift_d = 1'b1;
`ifdef PS2_CAPS_LOCK_EN
      // Held caps lock only toggles on the first make, not typematic repeats.
      if (scan_code == 8'h58) begin
        if (!caps_held_q) caps_d = ~caps_q;
        caps_held_d = 1'b1;
      end
`endif
    end
    if ((do_make || do_ext) && mapped != 8'h00 && !repeat_blocked) begin
      ascii_d     = mapped;
      key_d       = 1'b1;
      last_make_d = scan_code;
    end
    if (do_brk) begin
      if (scan_code == 8'h12) lshift_d = 1'b0;
      if (scan_code == 8'h59) rshift_d = 1'b0;
      if (scan_code == 8'h58) caps_held_d = 1'b0;
      if (scan_code == last_make_q) last_make_d = 8'h00;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ascii_q     <= 8'h00;
      key_q       <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      last_make_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      ascii_q     <= ascii_d;
      key_q       <= key_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      last_make_q <= last_make_d;
    end
  end

  assign ascii_char  = ascii_q;
  assign key_pressed = key_q;
  assign shift_held  = lshift_q | rshift_q;
  assign caps_on     = caps_q;

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Converts the PS/2 Set-2 scan-code byte stream from the keyboard receiver into one-cycle ASCII key events. It sits directly upstream of `ps2_processor_module` and drives that module's `ascii_char` and `key_pressed` inputs. It tracks make/break/extended prefixes, shift state and, optionally, caps lock. It never emits ASCII 0x00, so every `key_pressed` pulse is a real character, newline or backspace.

## Interface
- `SUPPRESS_REPEAT`, default 0: when 1, typematic repeats of a held key are dropped; when 0, each repeat emits an event.
- `clock` in 1: sole clock; all logic on posedge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `scan_code` in 8: received byte; valid only when `scan_ready`=1.
- `scan_ready` in 1: one-cycle strobe, one byte per strobe; back-to-back strobes allowed.
- `ascii_char` out 8: last emitted character; holds between events.
- `key_pressed` out 1: one-cycle pulse; `ascii_char` is valid in the same cycle.
- `shift_held` out 1: OR of left-shift and right-shift held flags.
- `caps_on` out 1: caps-lock toggle state; constant 0 when the feature is compiled out.

## Operation
- Reset values: `ascii_char`=0x00, `key_pressed`=0, `shift_held`=0, `caps_on`=0, FSM=IDLE, `last_make`=0x00, all held flags 0.
- Prefix FSM. Every transition requires `scan_ready`.
  - IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte is treated as a make code, and the FSM stays IDLE.
  - EXT: 0xF0 -> EXT_BRK; 0xE0 -> EXT; any other byte is an extended make, then -> IDLE.
  - BRK: 0xF0 -> BRK; 0xE0 -> EXT_BRK; any other byte is a break code, then -> IDLE.
  - EXT_BRK: 0xF0 or 0xE0 -> stay in EXT_BRK; any other byte is an extended break, then -> IDLE.
- Ignored bytes: 0x00, 0xAA, 0xEE, 0xFA, 0xFE and 0xFF are dropped in any state, and the FSM returns to IDLE.
- Make handling:
  - 0x12 and 0x59 set the left/right shift flags.
  - 0x58 is caps lock (see Configuration).
  - Mapped codes emit one event.
  - Unmapped codes are dropped silently.
- Break handling:
  - 0x12 and 0x59 clear the matching shift flag.
  - 0x58 clears the caps-held flag.
  - A break equal to `last_make` clears `last_make`.
  - A break never emits an event.
- Letter map, lowercase base:
  - 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i
  - 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q
  - 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z
  - A letter is uppercase (subtract 0x20) when `shift_held` XOR `caps_on`.
- Other codes, not shift-affected:
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 space (0x20), 49 '.', 4E '-', 41 ','.
  - 5A -> 0x0A, 66 -> 0x08.
- Extended makes: only E0 5A (keypad enter) maps, to 0x0A. All other extended makes are dropped and do not update `last_make`.
- Repeat rule with `SUPPRESS_REPEAT`=1: a mapped make equal to `last_make` emits nothing. Otherwise, emitting an event loads `last_make` with the event's code. With `SUPPRESS_REPEAT`=0, `last_make` is still tracked but never blocks an event.

## Timing
- Event latency is 1 cycle: a mapped make on `scan_ready` at edge N gives `key_pressed`=1 and the new `ascii_char` from edge N+1 for exactly one cycle.
- `shift_held` and `caps_on` update at edge N+1 after the strobe that carries their byte.
- The shift/caps state used to map a letter is the state registered before that letter's strobe.
- Back-to-back strobes on every cycle are processed without loss; the maximum event rate is one per cycle.
- Asserting `reset` mid-sequence (for example after 0xE0 or 0xF0) discards the pending prefix. A strobe arriving while `reset`=1 is ignored.

## Configuration
- `PS2_CAPS_LOCK_EN` defined:
  - A 0x58 make toggles `caps_on` only if the caps-held flag is 0, then sets caps-held.
  - Typematic 0x58 repeats do not re-toggle.
  - A 0x58 break clears caps-held.
- `PS2_CAPS_LOCK_EN` undefined:
  - 0x58 make and break are dropped.
  - `caps_on` is tied to 0.
  - Letter case depends only on `shift_held`.

## Test plan
- Bytes 1C, F0, 1C -> exactly one `key_pressed` pulse, with `ascii_char`=0x61, one cycle after the 1C strobe. No pulse for the break.
- Bytes 12, 1C, F0, 12, 1C -> events 0x41 then 0x61; `shift_held` reads 1 between the first 12 and the break, 0 after it.
- Bytes E0, 5A, E0, F0, 5A, then 66 -> events 0x0A and 0x08 only; the FSM is in IDLE after each sequence.
- `SUPPRESS_REPEAT`=1, bytes 2D, 2D, 2D, F0, 2D, 2D -> two 0x72 events (the first and last 2D). With `SUPPRESS_REPEAT`=0, the same input gives four events.
- With `PS2_CAPS_LOCK_EN` defined, bytes 58, 58, F0, 58, 15 -> `caps_on`=1 and event 0x51. Repeat with 12 held before 15 -> event 0x71.
- Bytes E0, F0, then `reset` pulsed, then 1C -> reset outputs all 0 and event 0x61 emitted, so the prefix was discarded. Bytes AA and FA -> no events.
